// File: rtl/lut_layer_pkg.sv
// Shared types for lut_layer_pipe: FSM state encoding and config index width helper.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Neuron-select width; a single-neuron layer still gets a 1-bit select.
  function automatic int nidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_layer_pipe_table.sv
// lut_table_ram: one neuron's 2^IN_BITS x OUT_BITS table, synchronous write, async read.
// LUT_LAYER_READBACK_EN adds a second async read port for config readback.
module lut_table_ram #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
`ifdef LUT_LAYER_READBACK_EN
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data,
`endif
  output logic [OUT_BITS-1:0] rdata
);

  (* rom_style = "distributed" *) logic [OUT_BITS-1:0] mem [2**IN_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef LUT_LAYER_READBACK_EN
  assign rb_data = mem[rb_addr];
`endif

endmodule

// File: rtl/lut_layer_pipe.sv
// lut_layer_pipe: NUM_NEURONS programmable truth tables behind a two-stage valid/ready pipeline.
// Optional macro LUT_LAYER_READBACK_EN adds a registered table readback port (CONFIG only).
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int NIDX_W      = nidx_w(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                            cfg_we,
  input  logic [NIDX_W-1:0]               cfg_nidx,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata,
  input  logic                            cfg_commit,
  input  logic                            cfg_unlock,
  output logic                            state_run,
`ifdef LUT_LAYER_READBACK_EN
  input  logic                            cfg_re,
  output logic [OUT_BITS-1:0]             cfg_rdata,
  output logic                            cfg_rvalid,
`endif
  output state_t                          state_dbg
);

  // Handshake: a word moves on a rising edge where valid & ready are both 1; a
  // producer holds valid/data until that edge, and ready may depend on valid.
  state_t                            state;
  logic                              s1_valid;
  logic [NUM_NEURONS*IN_BITS-1:0]    s1_data;
  logic [NUM_NEURONS*OUT_BITS-1:0]   lookup;
  logic                              s2_load;
  logic                              s1_load;
  logic                              accept;
  logic                              tbl_we;

  assign s2_load   = !m_valid || m_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign s_ready   = (state == ST_RUN) && s1_load;
  assign accept    = s_valid && s_ready;
  assign tbl_we    = (state == ST_CONFIG) && cfg_we;
  assign state_run = (state == ST_RUN);
  assign state_dbg = state;

`ifdef LUT_LAYER_READBACK_EN
  logic [OUT_BITS-1:0] rb_data [NUM_NEURONS];
`endif

  // Out-of-range cfg_nidx matches no neuron, so such writes fall on the floor.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic we_n;
    assign we_n = tbl_we && (cfg_nidx == NIDX_W'(n));

    lut_table_ram #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_tbl (
      .clk     (clk),
      .we      (we_n),
      .waddr   (cfg_addr),
      .wdata   (cfg_wdata),
      .raddr   (s1_data[n*IN_BITS +: IN_BITS]),
`ifdef LUT_LAYER_READBACK_EN
      .rb_addr (cfg_addr),
      .rb_data (rb_data[n]),
`endif
      .rdata   (lookup[n*OUT_BITS +: OUT_BITS])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CONFIG;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) s1_data <= s_data;
      end
      if (s2_load) begin
        m_valid <= s1_valid;
        if (s1_valid) m_data <= lookup;
      end
      unique case (state)
        ST_CONFIG: if (cfg_commit) state <= ST_RUN;
        ST_RUN:    if (cfg_unlock) state <= ST_DRAIN;
        ST_DRAIN:  if (!s1_valid && !m_valid) state <= ST_CONFIG;
        default:   state <= ST_CONFIG;
      endcase
    end
  end

`ifdef LUT_LAYER_READBACK_EN
  // The async read sees the pre-edge contents, so a same-entry write returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid <= 1'b0;
      cfg_rdata  <= '0;
    end else begin
      cfg_rvalid <= (state == ST_CONFIG) && cfg_re;
      if ((state == ST_CONFIG) && cfg_re)
        cfg_rdata <= (32'(cfg_nidx) < NUM_NEURONS) ? rb_data[cfg_nidx] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Self-checking bench for lut_layer_pipe (5-neuron layer so out-of-range neuron indices are reachable).
`timescale 1ns/1ps
module tb_lut_layer_pipe;
  import lut_layer_pkg::*;

  localparam int NN  = 5;
  localparam int IB  = 8;
  localparam int OB  = 1;
  localparam int NIW = nidx_w(NN);
  localparam int SW  = NN*IB;
  localparam int MW  = NN*OB;

  logic           clk;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [SW-1:0]  s_data;
  logic           m_valid;
  logic           m_ready;
  logic [MW-1:0]  m_data;
  logic           cfg_we;
  logic [NIW-1:0] cfg_nidx;
  logic [IB-1:0]  cfg_addr;
  logic [OB-1:0]  cfg_wdata;
  logic           cfg_commit;
  logic           cfg_unlock;
  logic           state_run;
  state_t         state_dbg;
`ifdef LUT_LAYER_READBACK_EN
  logic           cfg_re;
  logic [OB-1:0]  cfg_rdata;
  logic           cfg_rvalid;
`endif

  lut_layer_pipe #(.NUM_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .cfg_we     (cfg_we),
    .cfg_nidx   (cfg_nidx),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .cfg_unlock (cfg_unlock),
    .state_run  (state_run),
`ifdef LUT_LAYER_READBACK_EN
    .cfg_re     (cfg_re),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int rdy_mode = 0;
  logic tbl [NN][256];
  logic [MW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] model(input logic [SW-1:0] w);
    logic [MW-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) r[n] = tbl[n][w[n*IB +: IB]];
    return r;
  endfunction

  function automatic logic [SW-1:0] make_word(input logic [IB-1:0] s, input int slot);
    logic [SW-1:0] w;
    w = SW'({$urandom(), $urandom()});
    w[slot*IB +: IB] = s;
    return w;
  endfunction

  // Downstream ready pattern: 0 = always, 1 = 1-0-0-1 repeating, 2 = stalled
  initial begin
    int ph;
    ph = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 4;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (ph == 0) || (ph == 3);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall) check("hold_valid", 64'(m_valid), 64'(1));
        if (m_valid) begin
          if (exp_q.size() == 0) check("spurious_out", 64'(1), 64'(0));
          else begin
            check("m_data", 64'(m_data), 64'(exp_q[0]));
            if (m_ready) begin
              void'(exp_q.pop_front());
              n_out++;
            end
          end
        end
        prev_stall = m_valid && !m_ready;
      end
    end
  end

  // Driver tasks
  task automatic send_word(input logic [SW-1:0] w);
    int k;
    bit ok;
    k = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      k++;
    end
    if (ok) exp_q.push_back(model(w));
    else check("send_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic cfg_write(input int n, input int a, input logic v, input bit lands);
    cfg_we    = 1'b1;
    cfg_nidx  = NIW'(n);
    cfg_addr  = IB'(a);
    cfg_wdata = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (lands) tbl[n][a] = v;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    @(negedge clk);
    check("commit_run", 64'(state_run), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Needs an empty pipe and m_ready=1: checks the 2-cycle latency and one result bit.
  task automatic send_and_lat(input logic [SW-1:0] w, input int idx, input logic expbit);
    send_word(w);
    @(negedge clk);
    check("lat_c1_valid", 64'(m_valid), 64'(0));
    @(negedge clk);
    check("lat_c2_valid", 64'(m_valid), 64'(1));
    check("lat_bit", 64'(m_data[idx]), 64'(expbit));
    wait_empty(20);
  endtask

  initial begin
    int cnt0;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0;
    cfg_we = 1'b0; cfg_nidx = '0; cfg_addr = '0; cfg_wdata = '0;
    cfg_commit = 1'b0; cfg_unlock = 1'b0;
`ifdef LUT_LAYER_READBACK_EN
    cfg_re = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state_run", 64'(state_run), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(ST_CONFIG));
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. Program and stream
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < 256; a++)
        cfg_write(n, a, (n == 0) ? ((a == 'h98) ? 1'b1 : 1'b0) : a[0], 1'b1);
    cfg_write(5, 'h98, 1'b1, 1'b0);
    cfg_write(7, 'h01, 1'b0, 1'b0);
    s_valid = 1'b1;
    @(negedge clk);
    check("cfg_s_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_nidx = NIW'(2); cfg_addr = 8'h55; cfg_wdata = 1'b0;
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_commit = 1'b0;
    tbl[2]['h55] = 1'b0;
    @(negedge clk);
    check("commit_run", 64'(state_run), 64'(1));
    @(posedge clk); #1;
    send_and_lat(make_word(8'h98, 0), 0, 1'b1);
    send_and_lat(make_word(8'h18, 0), 0, 1'b0);
    send_and_lat(make_word(8'h55, 2), 2, 1'b0);
    send_and_lat(make_word(8'h98, 1), 1, 1'b0);

    // 2. Backpressure
    rdy_mode = 1;
    cnt0 = n_out;
    for (int i = 0; i < 16; i++) send_word(SW'({$urandom(), $urandom()}));
    wait_empty(300);
    check("bp_count", 64'(n_out - cnt0), 64'(16));
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;

    // 3. Writes ignored in RUN
    cfg_write(1, 'h0C, 1'b1, 1'b0);
    send_and_lat(make_word(8'h0C, 1), 1, 1'b0);

    // 4. Unlock with two words in flight
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    cnt0 = n_out;
    send_word(SW'({$urandom(), $urandom()}));
    cfg_unlock = 1'b1;
    send_word(SW'({$urandom(), $urandom()}));
    cfg_unlock = 1'b0;
    @(negedge clk);
    check("drain_s_ready", 64'(s_ready), 64'(0));
    check("drain_state_run", 64'(state_run), 64'(0));
    check("drain_state", 64'(state_dbg), 64'(ST_DRAIN));
    @(posedge clk); #1;
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    @(negedge clk);
    check("drain_commit_ignored", 64'(state_dbg), 64'(ST_DRAIN));
    rdy_mode = 0;
    wait_empty(50);
    check("drain_count", 64'(n_out - cnt0), 64'(2));
    repeat (3) @(negedge clk);
    check("drain_to_config", 64'(state_dbg), 64'(ST_CONFIG));
    @(posedge clk); #1;

    // 5. Reset mid-stream, then commit without reprogramming
    do_commit();
    rdy_mode = 2;
    repeat (2) @(posedge clk); #1;
    send_word(SW'({$urandom(), $urandom()}));
    send_word(SW'({$urandom(), $urandom()}));
    @(negedge clk);
    check("pre_rst_valid", 64'(m_valid), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_valid", 64'(m_valid), 64'(0));
    check("post_rst_run", 64'(state_run), 64'(0));
    check("post_rst_state", 64'(state_dbg), 64'(ST_CONFIG));
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    do_commit();
    send_and_lat(make_word(8'h98, 0), 0, 1'b1);
    cnt0 = n_out;
    for (int i = 0; i < 6; i++) send_word(SW'({$urandom(), $urandom()}));
    wait_empty(50);
    check("post_rst_count", 64'(n_out - cnt0), 64'(6));

`ifdef LUT_LAYER_READBACK_EN
    // 6. Readback
    cfg_unlock = 1'b1;
    @(posedge clk); #1;
    cfg_unlock = 1'b0;
    repeat (3) @(negedge clk);
    check("rb_config", 64'(state_dbg), 64'(ST_CONFIG));
    @(posedge clk); #1;
    cfg_write(3, 'hFF, 1'b1, 1'b1);
    cfg_re = 1'b1; cfg_nidx = NIW'(3); cfg_addr = 8'hFF;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    @(negedge clk);
    check("rb_valid", 64'(cfg_rvalid), 64'(1));
    check("rb_data", 64'(cfg_rdata), 64'(1));
    @(posedge clk); #1;
    cfg_re = 1'b1; cfg_we = 1'b1; cfg_wdata = 1'b0;
    @(posedge clk); #1;
    cfg_re = 1'b0; cfg_we = 1'b0;
    tbl[3]['hFF] = 1'b0;
    @(negedge clk);
    check("rb_old_value", 64'(cfg_rdata), 64'(1));
    @(posedge clk); #1;
    cfg_re = 1'b1;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    @(negedge clk);
    check("rb_new_value", 64'(cfg_rdata), 64'(0));
    @(posedge clk); #1;
    cfg_re = 1'b1; cfg_nidx = NIW'(NN); cfg_addr = 8'h98;
    @(posedge clk); #1;
    cfg_re = 1'b0;
    @(negedge clk);
    check("rb_oor_valid", 64'(cfg_rvalid), 64'(1));
    check("rb_oor_data", 64'(cfg_rdata), 64'(0));
    @(negedge clk);
    check("rb_valid_clear", 64'(cfg_rvalid), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
